// File: rtl/md_pkg.sv
// Shared op/state encodings and op-class helpers for the iterative multiply/divide unit.
// Build option: MD_UNIT_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package md_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    // How the pending product is merged into {hi,lo} at the commit edge.
    typedef enum logic [1:0] {
        ACC_SET = 2'd0,
        ACC_ADD = 2'd1,
        ACC_SUB = 2'd2
    } acc_mode_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        logic r;
        case (op)
            OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MD_UNIT_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        logic r;
        case (op)
            OP_DIV, OP_DIVU: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_long_op(input logic [3:0] op);
        return is_mul_op(op) | is_div_op(op);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        logic r;
        case (op)
            OP_MULT, OP_DIV, OP_MADD, OP_MSUB: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md_unit_iter_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_div_iter.sv
// Radix-2 restoring divider datapath: unsigned magnitudes in, one quotient bit per step.
module md_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   diff_s;

    // Trial subtraction of the divisor from the left-shifted partial remainder
    always_comb begin
        shift_s = {rem_r, quo_r[WIDTH-1]};
        diff_s  = shift_s - {1'b0, dvs_r};
    end

    // Quotient bits enter from the right as dividend bits leave from the left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r <= '0;
            quo_r <= '0;
            dvs_r <= '0;
        end else if (load) begin
            rem_r <= '0;
            quo_r <= dividend;
            dvs_r <= divisor;
        end else if (step) begin
            if (!diff_s[WIDTH]) begin
                rem_r <= diff_s[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b1};
            end else begin
                rem_r <= shift_s[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/md_unit_iter.sv
// EX-stage multiply/divide unit with HI/LO, pipelined-latency multiply and iterative divide.
// Build option: MD_UNIT_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulation into {hi,lo}.
module md_unit_iter
    import md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input logic          clk,
    input logic          rst_n,
    md_unit_iter_if.slave bus
);

    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;
    logic [2*WIDTH-1:0] pend_r;
    acc_mode_e          acc_r;
    logic               q_neg_r;
    logic               r_neg_r;

    logic               accept_s;
    logic               op_signed_s;
    logic               div_zero_s;
    logic               div_load_s;
    logic               div_step_s;
    logic               busy_s;
    logic [2*WIDTH-1:0] ext_a_s;
    logic [2*WIDTH-1:0] ext_b_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] mul_res_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    // Request decode, operand conditioning and busy (busy must cover the accept cycle)
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && bus.start && !bus.flush;
        op_signed_s = is_signed_op(bus.op);
        div_zero_s  = (bus.src_b == {WIDTH{1'b0}});
        div_load_s  = accept_s && is_div_op(bus.op) && !div_zero_s;
        div_step_s  = (state_r == ST_DIV) && !bus.flush;

        ext_a_s = {{WIDTH{op_signed_s & bus.src_a[WIDTH-1]}}, bus.src_a};
        ext_b_s = {{WIDTH{op_signed_s & bus.src_b[WIDTH-1]}}, bus.src_b};
        prod_s  = ext_a_s * ext_b_s;

        if (op_signed_s && bus.src_a[WIDTH-1]) begin
            mag_a_s = ~bus.src_a + WIDTH'(1);
        end else begin
            mag_a_s = bus.src_a;
        end
        if (op_signed_s && bus.src_b[WIDTH-1]) begin
            mag_b_s = ~bus.src_b + WIDTH'(1);
        end else begin
            mag_b_s = bus.src_b;
        end

        if (state_r != ST_IDLE) begin
            busy_s = 1'b1;
        end else begin
            busy_s = accept_s && is_long_op(bus.op) && !(is_div_op(bus.op) && div_zero_s);
        end
    end

    // Commit values: accumulate mode for the multiply, sign restore for the divide
    always_comb begin
        case (acc_r)
            ACC_ADD: mul_res_s = {hi_r, lo_r} + pend_r;
            ACC_SUB: mul_res_s = {hi_r, lo_r} - pend_r;
            default: mul_res_s = pend_r;
        endcase
        if (q_neg_r) begin
            quo_fix_s = ~quo_s + WIDTH'(1);
        end else begin
            quo_fix_s = quo_s;
        end
        if (r_neg_r) begin
            rem_fix_s = ~rem_s + WIDTH'(1);
        end else begin
            rem_fix_s = rem_s;
        end
    end

    md_div_iter #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load_s),
        .step     (div_step_s),
        .dividend (mag_a_s),
        .divisor  (mag_b_s),
        .quotient (quo_s),
        .remainder(rem_s)
    );

    // Sequencer, HI/LO and pending-result registers; flush wins over any commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            done_r  <= 1'b0;
            pend_r  <= '0;
            acc_r   <= ACC_SET;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        case (bus.op)
                            OP_MTHI: hi_r <= bus.src_a;
                            OP_MTLO: lo_r <= bus.src_a;
                            OP_MULT, OP_MULTU: begin
                                pend_r  <= prod_s;
                                acc_r   <= ACC_SET;
                                cnt_r   <= CNT_MUL;
                                state_r <= ST_MUL;
                            end
`ifdef MD_UNIT_MADD_EN
                            OP_MADD, OP_MADDU: begin
                                pend_r  <= prod_s;
                                acc_r   <= ACC_ADD;
                                cnt_r   <= CNT_MUL;
                                state_r <= ST_MUL;
                            end
                            OP_MSUB, OP_MSUBU: begin
                                pend_r  <= prod_s;
                                acc_r   <= ACC_SUB;
                                cnt_r   <= CNT_MUL;
                                state_r <= ST_MUL;
                            end
`endif
                            OP_DIV, OP_DIVU: begin
                                // A zero divisor drops the op without touching HI/LO
                                if (!div_zero_s) begin
                                    q_neg_r <= op_signed_s & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                                    r_neg_r <= op_signed_s & bus.src_a[WIDTH-1];
                                    cnt_r   <= CNT_DIV;
                                    state_r <= ST_DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (bus.flush) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else if (cnt_r == CNT_ONE) begin
                        {hi_r, lo_r} <= mul_res_s;
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DIV: begin
                    if (bus.flush) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                        if (cnt_r == CNT_ONE) begin
                            state_r <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    if (!bus.flush) begin
                        lo_r   <= quo_fix_s;
                        hi_r   <= rem_fix_s;
                        done_r <= 1'b1;
                    end
                    state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_s;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule
